field_sweep: RTL and testbench

FIELD_SWEEP -- requirements
Module: field_sweep

---
 rtl/field_sweep.sv | 152 +++++++++++++++
 tb/tb_field_sweep.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_sweep.sv
// field_sweep: one damping pass over a BRAM-resident vector field.
// Reads every cell in row-major order and writes back v - (v >>> DECAY_SHIFT)
// per channel. Border cells can optionally be forced to zero. The path is
// read -> compute -> write, one cell per cycle, and can be paused with hold.
module field_sweep #(
    parameter int unsigned FIELD_WIDTH  = 80,
    parameter int unsigned FIELD_HEIGHT = 60,
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned CHAN_W       = 32,
    parameter int unsigned DECAY_SHIFT  = 4,
    parameter int unsigned BORDER_MODE  = 1,
    localparam int unsigned DATAW      = CHANNELS * CHAN_W,
    localparam int unsigned FIELD_SIZE = FIELD_WIDTH * FIELD_HEIGHT,
    localparam int unsigned ADDRW      = $clog2(FIELD_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic [ADDRW-1:0] rd_addr,
    input  logic [DATAW-1:0] rd_data,
    output logic             wr_en,
    output logic [ADDRW-1:0] wr_addr,
    output logic [DATAW-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sweep_count
);

    localparam int unsigned XWidth = $clog2(FIELD_WIDTH);
    localparam int unsigned YWidth = $clog2(FIELD_HEIGHT);
    localparam logic [XWidth-1:0] XLast = XWidth'(FIELD_WIDTH - 1);
    localparam logic [YWidth-1:0] YLast = YWidth'(FIELD_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;

    state_e            state_q;
    logic [XWidth-1:0] x_q;
    logic [YWidth-1:0] y_q;
    logic [ADDRW-1:0]  addr_q;
    logic              s1_valid_q;
    logic [ADDRW-1:0]  s1_addr_q;
    logic              s1_border_q;
    logic              wr_en_q;
    logic [ADDRW-1:0]  wr_addr_q;
    logic [DATAW-1:0]  wr_data_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       sweep_cnt_q;

    logic              on_border;
    logic              last_cell;
    logic [DATAW-1:0]  damped;

    assign on_border = (x_q == '0) || (x_q == XLast) || (y_q == '0) || (y_q == YLast);
    assign last_cell = (x_q == XLast) && (y_q == YLast);

    // Per-channel damping of the word returned by the BRAM this cycle.
    always_comb begin
        damped = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            damped[i*CHAN_W +: CHAN_W] = rd_data[i*CHAN_W +: CHAN_W]
                - CHAN_W'($signed(rd_data[i*CHAN_W +: CHAN_W]) >>> DECAY_SHIFT);
        end
    end

    // Sweep FSM: scan counters, read issue, stage-1 tracking and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_border_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sweep_cnt_q <= '0;
        end else begin
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StSweep;
                        busy_q  <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= '0;
                    end
                end
                StSweep: begin
                    // A held cycle issues nothing and freezes the scan position.
                    if (!hold) begin
                        s1_valid_q  <= 1'b1;
                        s1_addr_q   <= addr_q;
                        s1_border_q <= on_border;
                        if (last_cell) begin
                            x_q     <= '0;
                            y_q     <= '0;
                            addr_q  <= '0;
                            state_q <= StDrain;
                        end else begin
                            addr_q <= addr_q + ADDRW'(1);
                            if (x_q == XLast) begin
                                x_q <= '0;
                                y_q <= y_q + YWidth'(1);
                            end else begin
                                x_q <= x_q + XWidth'(1);
                            end
                        end
                    end
                end
                StDrain: begin
                    // Stage 1 empty means the final write is on the bus this cycle.
                    if (!s1_valid_q) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        sweep_cnt_q <= sweep_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Write stage: register the damped (or zeroed border) word with its address.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= s1_valid_q;
            if (s1_valid_q) begin
                wr_addr_q <= s1_addr_q;
                wr_data_q <= ((BORDER_MODE != 0) && s1_border_q) ? '0 : damped;
            end
        end
    end

    assign rd_addr     = addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sweep_count = sweep_cnt_q;

endmodule

// File: tb/tb_field_sweep.sv
// Bench for field_sweep: three instances (4x3 interior-damped, 4x3 zeroed
// border, default 80x60) each fed by a small BRAM model and write monitor.
module tb_field_sweep;

    localparam int DW = 96;
    localparam int SA = 12;
    localparam int SC = 4800;

    logic clk;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic          rst_a, start_a, hold_a, wr_en_a, busy_a, done_a;
    logic [3:0]    rd_addr_a, wr_addr_a;
    logic [DW-1:0] rd_data_a, wr_data_a;
    logic [15:0]   cnt_a;

    logic          rst_b, start_b, hold_b, wr_en_b, busy_b, done_b;
    logic [3:0]    rd_addr_b, wr_addr_b;
    logic [DW-1:0] rd_data_b, wr_data_b;
    logic [15:0]   cnt_b;

    logic          rst_c, start_c, hold_c, wr_en_c, busy_c, done_c;
    logic [12:0]   rd_addr_c, wr_addr_c;
    logic [DW-1:0] rd_data_c, wr_data_c;
    logic [15:0]   cnt_c;

    logic [DW-1:0] mem_a [SA];
    logic [DW-1:0] mem_b [SA];
    logic [DW-1:0] mem_c [SC];

    int            wa_a[$], wa_b[$], wa_c[$];
    logic [DW-1:0] wd_a[$], wd_b[$], wd_c[$];

    field_sweep #(.FIELD_WIDTH(4), .FIELD_HEIGHT(3), .BORDER_MODE(0)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .hold(hold_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .done(done_a), .sweep_count(cnt_a)
    );

    field_sweep #(.FIELD_WIDTH(4), .FIELD_HEIGHT(3), .BORDER_MODE(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .hold(hold_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .sweep_count(cnt_b)
    );

    field_sweep dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .hold(hold_c),
        .rd_addr(rd_addr_c), .rd_data(rd_data_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_data(wr_data_c), .busy(busy_c), .done(done_c), .sweep_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM models: one-cycle read latency; contents are the pre-sweep image.
    always @(posedge clk) begin
        rd_data_a <= mem_a[rd_addr_a];
        rd_data_b <= mem_b[rd_addr_b];
        rd_data_c <= mem_c[rd_addr_c];
    end

    // Write monitors.
    always @(negedge clk) begin
        if (wr_en_a === 1'b1) begin wa_a.push_back(int'(wr_addr_a)); wd_a.push_back(wr_data_a); end
        if (wr_en_b === 1'b1) begin wa_b.push_back(int'(wr_addr_b)); wd_b.push_back(wr_data_b); end
        if (wr_en_c === 1'b1) begin wa_c.push_back(int'(wr_addr_c)); wd_c.push_back(wr_data_c); end
    end

    // Reference: each signed channel loses floor(v/16); zero for border cells.
    function automatic logic [DW-1:0] ref_cell(input logic [DW-1:0] v, input bit zero);
        logic [DW-1:0] r;
        longint s, q;
        r = '0;
        if (!zero) begin
            for (int i = 0; i < 3; i++) begin
                s = longint'($signed(v[i*32 +: 32]));
                if (s >= 0) q = s / 16;
                else q = -((-s + 15) / 16);
                r[i*32 +: 32] = 32'(s - q);
            end
        end
        return r;
    endfunction

    function automatic bit is_border(input int a, input int fw, input int fh);
        int x, y;
        x = a % fw;
        y = a / fw;
        return (x == 0) || (x == fw - 1) || (y == 0) || (y == fh - 1);
    endfunction

    function automatic logic [31:0] big_chan();
        logic [31:0] v;
        v = $urandom;
        if ($signed(v) > -32 && $signed(v) < 32) v = 32'h0001_2340;
        return v;
    endfunction

    task automatic test_reset();
        n_chk++; if ({wr_en_a, busy_a, done_a} !== 3'b000) $display("FAIL reset_ctrl_a got %b want 000", {wr_en_a, busy_a, done_a}); else n_pass++;
        n_chk++; if (rd_addr_a !== 4'd0) $display("FAIL reset_rd_addr_a got %0d want 0", rd_addr_a); else n_pass++;
        n_chk++; if (wr_addr_a !== 4'd0) $display("FAIL reset_wr_addr_a got %0d want 0", wr_addr_a); else n_pass++;
        n_chk++; if (wr_data_a !== '0) $display("FAIL reset_wr_data_a got %h want 0", wr_data_a); else n_pass++;
        n_chk++; if (cnt_a !== 16'd0) $display("FAIL reset_count_a got %h want 0", cnt_a); else n_pass++;
        n_chk++; if ({wr_en_b, busy_b, done_b} !== 3'b000) $display("FAIL reset_ctrl_b got %b want 000", {wr_en_b, busy_b, done_b}); else n_pass++;
        n_chk++; if (cnt_b !== 16'd0) $display("FAIL reset_count_b got %h want 0", cnt_b); else n_pass++;
        n_chk++; if ({wr_en_c, busy_c, done_c} !== 3'b000) $display("FAIL reset_ctrl_c got %b want 000", {wr_en_c, busy_c, done_c}); else n_pass++;
        n_chk++; if (rd_addr_c !== 13'd0) $display("FAIL reset_rd_addr_c got %0d want 0", rd_addr_c); else n_pass++;
        n_chk++; if (wr_addr_c !== 13'd0 || wr_data_c !== '0) $display("FAIL reset_wr_c got %0d/%h want 0/0", wr_addr_c, wr_data_c); else n_pass++;
        n_chk++; if (cnt_c !== 16'd0) $display("FAIL reset_count_c got %h want 0", cnt_c); else n_pass++;
    endtask

    // Cycle-exact timeline of one 4x3 sweep, all channels 0x100.
    task automatic test_basic();
        bit exp_we;
        for (int i = 0; i < SA; i++) mem_a[i] = {3{32'h0000_0100}};
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) @(negedge clk);
            exp_we = (k >= 3 && k <= 14);
            if (k <= 12) begin
                n_chk++; if (rd_addr_a !== 4'(k - 1)) $display("FAIL basic_rd_addr k=%0d got %0d want %0d", k, rd_addr_a, k - 1); else n_pass++;
            end
            n_chk++; if (wr_en_a !== exp_we) $display("FAIL basic_wr_en k=%0d got %b want %b", k, wr_en_a, exp_we); else n_pass++;
            if (exp_we) begin
                n_chk++; if (wr_addr_a !== 4'(k - 3)) $display("FAIL basic_wr_addr k=%0d got %0d want %0d", k, wr_addr_a, k - 3); else n_pass++;
                n_chk++; if (wr_data_a !== {3{32'h0000_00F0}}) $display("FAIL basic_wr_data k=%0d got %h want 0xF0 per channel", k, wr_data_a); else n_pass++;
            end
            n_chk++; if (done_a !== (k == 15)) $display("FAIL basic_done k=%0d got %b want %b", k, done_a, (k == 15)); else n_pass++;
            n_chk++; if (busy_a !== (k <= 14)) $display("FAIL basic_busy k=%0d got %b want %b", k, busy_a, (k <= 14)); else n_pass++;
        end
        n_chk++; if (cnt_a !== 16'd1) $display("FAIL basic_count got %0d want 1", cnt_a); else n_pass++;
    endtask

    // Random signed values plus the two arithmetic-shift corner words.
    task automatic test_values();
        int t, bad;
        logic [DW-1:0] got;
        for (int i = 0; i < SA; i++) mem_a[i] = {$urandom, $urandom, $urandom};
        mem_a[4][31:0]  = 32'hFFFF_FF00;
        mem_a[7][95:64] = 32'h8000_0000;
        wa_a.delete(); wd_a.delete();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        t = 0;
        while (done_a !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_chk++; if (done_a !== 1'b1) $display("FAIL values_done timeout got %b want 1", done_a); else n_pass++;
        n_chk++; if (wa_a.size() != SA) $display("FAIL values_count got %0d want %0d", wa_a.size(), SA); else n_pass++;
        bad = 0;
        for (int i = 0; i < wa_a.size(); i++)
            if (wa_a[i] != i || wd_a[i] !== ref_cell(mem_a[i], 1'b0)) bad++;
        n_chk++; if (bad != 0) $display("FAIL values_data got %0d bad writes want 0", bad); else n_pass++;
        got = (wd_a.size() > 4) ? wd_a[4] : 'x;
        n_chk++; if (got[31:0] !== 32'hFFFF_FF10) $display("FAIL values_neg256 got %h want ffffff10", got[31:0]); else n_pass++;
        got = (wd_a.size() > 7) ? wd_a[7] : 'x;
        n_chk++; if (got[95:64] !== 32'h8800_0000) $display("FAIL values_min got %h want 88000000", got[95:64]); else n_pass++;
    endtask

    task automatic test_border();
        int t, bad;
        logic [11:0] nz;
        for (int i = 0; i < SA; i++) mem_b[i] = {big_chan(), big_chan(), big_chan()};
        wa_b.delete(); wd_b.delete();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        t = 0;
        while (done_b !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_chk++; if (done_b !== 1'b1) $display("FAIL border_done timeout got %b want 1", done_b); else n_pass++;
        nz = '0;
        bad = 0;
        for (int i = 0; i < wa_b.size(); i++) begin
            if (wa_b[i] != i || wd_b[i] !== ref_cell(mem_b[i], is_border(i, 4, 3))) bad++;
            if (wd_b[i] != '0 && wa_b[i] >= 0 && wa_b[i] < SA) nz[wa_b[i]] = 1'b1;
        end
        n_chk++; if (wa_b.size() != SA || bad != 0) $display("FAIL border_data got %0d writes %0d bad want %0d writes 0 bad", wa_b.size(), bad, SA); else n_pass++;
        n_chk++; if (nz !== 12'h060) $display("FAIL border_nonzero_set got %h want 060", nz); else n_pass++;
    endtask

    // Full 80x60 sweep with a 5-cycle hold at cell 1000, then random holds.
    task automatic test_hold();
        int t, bad_a, bad_d;
        for (int i = 0; i < SC; i++) mem_c[i] = {$urandom, $urandom, $urandom};
        wa_c.delete(); wd_c.delete();
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        t = 0;
        while (rd_addr_c !== 13'd1000 && t < 3000) begin @(negedge clk); t++; end
        n_chk++; if (rd_addr_c !== 13'd1000) $display("FAIL hold_reach got %0d want 1000", rd_addr_c); else n_pass++;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) @(negedge clk);
            hold_c = (j < 5);
            n_chk++; if (wr_en_c !== (j < 2)) $display("FAIL hold_wr_en j=%0d got %b want %b", j, wr_en_c, (j < 2)); else n_pass++;
            if (j <= 5) begin
                n_chk++; if (rd_addr_c !== 13'd1000) $display("FAIL hold_frozen j=%0d got %0d want 1000", j, rd_addr_c); else n_pass++;
            end
        end
        t = 0;
        while (done_c !== 1'b1 && t < 20000) begin
            hold_c = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            t++;
        end
        hold_c = 1'b0;
        n_chk++; if (done_c !== 1'b1) $display("FAIL hold_done timeout got %b want 1", done_c); else n_pass++;
        n_chk++; if (wa_c.size() != SC) $display("FAIL hold_write_count got %0d want %0d", wa_c.size(), SC); else n_pass++;
        bad_a = 0;
        bad_d = 0;
        for (int i = 0; i < wa_c.size(); i++) begin
            if (wa_c[i] != i) bad_a++;
            if (wd_c[i] !== ref_cell(mem_c[i], is_border(i, 80, 60))) bad_d++;
        end
        n_chk++; if (bad_a != 0) $display("FAIL hold_order got %0d out-of-order want 0", bad_a); else n_pass++;
        n_chk++; if (bad_d != 0) $display("FAIL hold_data got %0d bad words want 0", bad_d); else n_pass++;
        n_chk++; if (cnt_c !== 16'd1) $display("FAIL hold_count got %0d want 1", cnt_c); else n_pass++;
    endtask

    // Reset at cell 100 together with start and hold, then a clean restart.
    task automatic test_reset_mid();
        int t, n0;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        t = 0;
        while (rd_addr_c !== 13'd100 && t < 500) begin @(negedge clk); t++; end
        n_chk++; if (rd_addr_c !== 13'd100) $display("FAIL rstmid_reach got %0d want 100", rd_addr_c); else n_pass++;
        rst_c = 1'b1; start_c = 1'b1; hold_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0; start_c = 1'b0; hold_c = 1'b0;
        n_chk++; if ({wr_en_c, busy_c, done_c} !== 3'b000) $display("FAIL rstmid_ctrl got %b want 000", {wr_en_c, busy_c, done_c}); else n_pass++;
        n_chk++; if (cnt_c !== 16'd0) $display("FAIL rstmid_count got %0d want 0", cnt_c); else n_pass++;
        n_chk++; if (rd_addr_c !== 13'd0) $display("FAIL rstmid_rd_addr got %0d want 0", rd_addr_c); else n_pass++;
        n0 = wa_c.size();
        repeat (3) @(negedge clk);
        n_chk++; if (wa_c.size() != n0 || busy_c !== 1'b0) $display("FAIL rstmid_quiet got %0d late writes busy=%b want 0/0", wa_c.size() - n0, busy_c); else n_pass++;
        wa_c.delete(); wd_c.delete();
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        n_chk++; if (busy_c !== 1'b1 || rd_addr_c !== 13'd0) $display("FAIL rstmid_restart got busy=%b rd_addr=%0d want 1/0", busy_c, rd_addr_c); else n_pass++;
        t = 0;
        while (done_c !== 1'b1 && t < 6000) begin @(negedge clk); t++; end
        n_chk++; if (done_c !== 1'b1) $display("FAIL rstmid_done timeout got %b want 1", done_c); else n_pass++;
        n_chk++; if (wa_c.size() != SC || wa_c[0] != 0 || wa_c[SC-1] != SC - 1) $display("FAIL rstmid_sweep got %0d writes want %0d from addr 0", wa_c.size(), SC); else n_pass++;
        n_chk++; if (cnt_c !== 16'd1) $display("FAIL rstmid_count2 got %0d want 1", cnt_c); else n_pass++;
    endtask

    // start held high: consecutive sweeps every 15 cycles, count wraps.
    task automatic test_back_to_back();
        int t, nd, last;
        logic [15:0] exp_cnt;
        @(negedge clk); force dut_a.sweep_cnt_q = 16'hFFFD;
        @(negedge clk); release dut_a.sweep_cnt_q;
        start_a = 1'b1;
        last = cyc;
        nd = 0;
        t = 0;
        while (nd < 4 && t < 200) begin
            @(negedge clk);
            t++;
            if (done_a === 1'b1) begin
                nd++;
                exp_cnt = 16'((65533 + nd) % 65536);
                n_chk++; if (cnt_a !== exp_cnt) $display("FAIL b2b_count sweep=%0d got %h want %h", nd, cnt_a, exp_cnt); else n_pass++;
                n_chk++; if (cyc - last != 15) $display("FAIL b2b_period sweep=%0d got %0d want 15", nd, cyc - last); else n_pass++;
                last = cyc;
                if (nd == 4) start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        n_chk++; if (nd != 4) $display("FAIL b2b_sweeps got %0d want 4", nd); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (busy_a !== 1'b0 || cnt_a !== 16'h0001) $display("FAIL b2b_idle got busy=%b count=%h want 0/0001", busy_a, cnt_a); else n_pass++;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        hold_a = 1'b0; hold_b = 1'b0; hold_c = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        test_basic();
        test_values();
        test_border();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
